spawnout_queue_drain: RTL and testbench

Drains task descriptors from the spawn-out queue and streams them out as 64-bit AXI-Stream packets. It sits directly downstream of the Scheduler spawn-out writer. It shares the queue BRAM through the second port. It reads each valid slot, emits every word of the slot in order, zeroes the consumed words, and releases the slot by clearing its header last.

---
 rtl/spawnout_queue_drain_pkg.sv | 38 +++
 rtl/spawnout_queue_drain_if.sv | 24 ++
 rtl/spawnout_queue_drain.sv | 155 +++++++++++++++
 tb/tb_spawnout_queue_drain.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spawnout_queue_drain_pkg.sv
// Shared scheduler definitions: spawn-out slot header layout, slot sizing and drain states.
package spawnout_queue_drain_pkg;

  localparam int VALID_BIT        = 63;
  localparam int COPIES_MSB       = 31;
  localparam int COPIES_LSB       = 24;
  localparam int DEPS_MSB         = 23;
  localparam int DEPS_LSB         = 16;
  localparam int ARGS_MSB         = 15;
  localparam int ARGS_LSB         = 8;
  localparam int SLOT_FIXED_WORDS = 4;
  localparam int COPY_WORDS       = 3;
  localparam int LEN_W            = 11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR_RD,
    ST_HDR_LATCH,
    ST_HDR_SEND,
    ST_WORD_RD,
    ST_WORD_LATCH,
    ST_WORD_SEND,
    ST_WORD_CLR,
    ST_HDR_CLR
  } drain_state_e;

  // Total slot length in words; 11 bits holds the worst case of 4 + 255 + 255 + 3*255.
  function automatic logic [LEN_W-1:0] slot_len(input logic [63:0] hdr);
    logic [LEN_W-1:0] n_args;
    logic [LEN_W-1:0] n_deps;
    logic [LEN_W-1:0] n_copies;
    n_args   = LEN_W'(hdr[ARGS_MSB:ARGS_LSB]);
    n_deps   = LEN_W'(hdr[DEPS_MSB:DEPS_LSB]);
    n_copies = LEN_W'(hdr[COPIES_MSB:COPIES_LSB]);
    return LEN_W'(SLOT_FIXED_WORDS) + n_args + n_deps + LEN_W'(COPY_WORDS) * n_copies;
  endfunction

endpackage

// File: rtl/spawnout_queue_drain_if.sv
// Queue BRAM port plus outgoing AXI-Stream, as seen by the drain (master) and its surroundings (slave).
interface spawnout_queue_drain_if;
  logic [31:0] spawnout_queue_addr;
  logic        spawnout_queue_en;
  logic [7:0]  spawnout_queue_we;
  logic [63:0] spawnout_queue_din;
  logic [63:0] spawnout_queue_dout;
  logic [63:0] outStream_TDATA;
  logic        outStream_TVALID;
  logic        outStream_TREADY;
  logic        outStream_TLAST;

  modport master (
    output spawnout_queue_addr, spawnout_queue_en, spawnout_queue_we, spawnout_queue_din,
    output outStream_TDATA, outStream_TVALID, outStream_TLAST,
    input  spawnout_queue_dout, outStream_TREADY
  );

  modport slave (
    input  spawnout_queue_addr, spawnout_queue_en, spawnout_queue_we, spawnout_queue_din,
    input  outStream_TDATA, outStream_TVALID, outStream_TLAST,
    output spawnout_queue_dout, outStream_TREADY
  );
endinterface

// File: rtl/spawnout_queue_drain.sv
// Spawn-out queue drain: streams each valid slot out, zeroes its body, then frees the header.
//
// state        | meaning
// IDLE         | waiting for enable
// HDR_RD       | read header word at rd_ptr
// HDR_LATCH    | capture header; invalid header polls back to IDLE
// HDR_SEND     | header beat on the stream
// WORD_RD      | read body word i
// WORD_LATCH   | capture body word i
// WORD_SEND    | body beat on the stream, TLAST on the final word
// WORD_CLR     | zero body word i, advance i
// HDR_CLR      | zero header (slot released), advance rd_ptr
module spawnout_queue_drain
  import spawnout_queue_drain_pkg::*;
#(
  parameter int QUEUE_LEN = 1024
) (
  input logic                   clk,
  input logic                   rstn,
  input logic                   enable,
  spawnout_queue_drain_if.master q_if
);

  localparam int IDX_W = $clog2(QUEUE_LEN);

  drain_state_e     state_q, state_d;
  logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0] i_q, i_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [63:0]      data_q, data_d;
  logic             en_q, en_d;
  logic [7:0]       we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic [IDX_W-1:0] word_idx;
  logic             last_word;

  function automatic logic [31:0] byte_addr(input logic [IDX_W-1:0] idx);
    return 32'(idx) << 3;
  endfunction

  assign last_word = (i_q == len_q - LEN_W'(1));

  // Next-state, slot pointer and word-counter logic.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    i_d      = i_q;
    len_d    = len_q;
    data_d   = data_q;
    case (state_q)
      ST_IDLE:       if (enable) state_d = ST_HDR_RD;
      ST_HDR_RD:     state_d = ST_HDR_LATCH;
      ST_HDR_LATCH: begin
        data_d = q_if.spawnout_queue_dout;
        if (q_if.spawnout_queue_dout[VALID_BIT]) begin
          len_d   = slot_len(q_if.spawnout_queue_dout);
          i_d     = LEN_W'(1);
          state_d = ST_HDR_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR_SEND:   if (q_if.outStream_TREADY) state_d = ST_WORD_RD;
      ST_WORD_RD:    state_d = ST_WORD_LATCH;
      ST_WORD_LATCH: begin
        data_d  = q_if.spawnout_queue_dout;
        state_d = ST_WORD_SEND;
      end
      ST_WORD_SEND:  if (q_if.outStream_TREADY) state_d = ST_WORD_CLR;
      ST_WORD_CLR: begin
        i_d     = i_q + LEN_W'(1);
        state_d = last_word ? ST_HDR_CLR : ST_WORD_RD;
      end
      ST_HDR_CLR: begin
        rd_ptr_d = rd_ptr_q + IDX_W'(len_q);
        state_d  = ST_IDLE;
      end
      default:       state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the upcoming state so they can be registered alongside it.
  always_comb begin
    en_d     = 1'b0;
    we_d     = 8'h00;
    addr_d   = 32'h0;
    tvalid_d = 1'b0;
    tlast_d  = 1'b0;
    word_idx = rd_ptr_d + IDX_W'(i_d);
    case (state_d)
      ST_HDR_RD: begin
        en_d   = 1'b1;
        addr_d = byte_addr(rd_ptr_d);
      end
      ST_HDR_SEND:  tvalid_d = 1'b1;
      ST_WORD_RD: begin
        en_d   = 1'b1;
        addr_d = byte_addr(word_idx);
      end
      ST_WORD_SEND: begin
        tvalid_d = 1'b1;
        tlast_d  = (i_d == len_d - LEN_W'(1));
      end
      ST_WORD_CLR: begin
        en_d   = 1'b1;
        we_d   = 8'hFF;
        addr_d = byte_addr(word_idx);
      end
      ST_HDR_CLR: begin
        en_d   = 1'b1;
        we_d   = 8'hFF;
        addr_d = byte_addr(rd_ptr_d);
      end
      default: ;
    endcase
  end

  // State, slot context and registered outputs; reset aborts any slot in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      i_q      <= '0;
      len_q    <= '0;
      data_q   <= '0;
      en_q     <= 1'b0;
      we_q     <= 8'h00;
      addr_q   <= 32'h0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      i_q      <= i_d;
      len_q    <= len_d;
      data_q   <= data_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  assign q_if.spawnout_queue_addr = addr_q;
  assign q_if.spawnout_queue_en   = en_q;
  assign q_if.spawnout_queue_we   = we_q;
  assign q_if.spawnout_queue_din  = 64'h0;
  assign q_if.outStream_TDATA     = data_q;
  assign q_if.outStream_TVALID    = tvalid_q;
  assign q_if.outStream_TLAST     = tlast_q;

endmodule

// File: tb/tb_spawnout_queue_drain.sv
// Bench for spawnout_queue_drain with a 16-word queue BRAM model and a beat scoreboard.
module tb_spawnout_queue_drain;

  localparam int QL = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic enable = 1'b0;

  spawnout_queue_drain_if q_if ();

  spawnout_queue_drain #(.QUEUE_LEN(QL)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .enable(enable),
    .q_if  (q_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [63:0] mem [QL];
  logic        ld_en = 1'b0;
  logic        ld_clr = 1'b0;
  logic [3:0]  ld_idx = 4'h0;
  logic [63:0] ld_data = 64'h0;
  int          rd_log[$];
  int          clr_log[$];
  logic [63:0] slot_w [80];

  // Queue BRAM: bench loads take priority, otherwise the DUT port with 1-cycle read latency.
  always @(posedge clk) begin
    if (ld_clr) begin
      for (int k = 0; k < QL; k++) mem[k] <= 64'h0;
    end else if (ld_en) begin
      mem[ld_idx] <= ld_data;
    end else if (q_if.spawnout_queue_en) begin
      q_if.spawnout_queue_dout <= mem[q_if.spawnout_queue_addr[6:3]];
      for (int b = 0; b < 8; b++)
        if (q_if.spawnout_queue_we[b])
          mem[q_if.spawnout_queue_addr[6:3]][8*b +: 8] <= q_if.spawnout_queue_din[8*b +: 8];
      if (q_if.spawnout_queue_we == 8'h00) rd_log.push_back(int'(q_if.spawnout_queue_addr));
      else clr_log.push_back(int'(q_if.spawnout_queue_addr));
    end
  end

  task automatic do_reset();
    rstn = 1'b0;
    enable = 1'b0;
    q_if.outStream_TREADY = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_mem();
    @(negedge clk);
    ld_clr = 1'b1;
    @(negedge clk);
    ld_clr = 1'b0;
  endtask

  task automatic load_slot(input int base, input int len);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      ld_en = 1'b1;
      ld_idx = 4'((base + k) % QL);
      ld_data = slot_w[k];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic set_min_slot();
    slot_w[0] = 64'h8000000000000000;
    slot_w[1] = 64'h1234567887654321;
    slot_w[2] = 64'h8765432112345678;
    slot_w[3] = 64'h0000000311223344;
  endtask

  // Runs one slot to completion; the scoreboard is filled from slot_w before the slot starts.
  task automatic drain_slot(input string name, input int base, input int len,
                            input int stall_beat, input int stall_len);
    logic [64:0] exp_q[$];
    logic [64:0] e;
    int rd0, clr0, cycles, beat, stall_cnt, nerr, exp_addr;
    bit started, done;
    for (int k = 0; k < len; k++) exp_q.push_back({(k == len - 1), slot_w[k]});
    rd0 = rd_log.size();
    clr0 = clr_log.size();
    started = 0; done = 0; cycles = 0; beat = 0; stall_cnt = 0;
    @(negedge clk);
    enable = 1'b1;
    for (int c = 0; c < 800 && !done; c++) begin
      @(negedge clk);
      if (!started && q_if.spawnout_queue_en) begin
        started = 1;
        total++;
        if (q_if.spawnout_queue_addr !== 32'(base * 8)) begin
          bad++;
          $display("FAIL %s first_read addr got %h want %h", name, q_if.spawnout_queue_addr, base * 8);
        end
      end
      if (started) cycles++;
      if (beat == stall_beat && q_if.outStream_TVALID && stall_cnt < stall_len) begin
        q_if.outStream_TREADY = 1'b0;
        stall_cnt++;
      end else begin
        q_if.outStream_TREADY = 1'b1;
      end
      if (q_if.outStream_TVALID) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL %s extra_beat got %h want none", name, q_if.outStream_TDATA);
        end else if (!q_if.outStream_TREADY) begin
          if ({q_if.outStream_TLAST, q_if.outStream_TDATA} !== exp_q[0] || q_if.spawnout_queue_en !== 1'b0) begin
            bad++;
            $display("FAIL %s stall_hold got last=%b data=%h en=%b want last=%b data=%h en=0", name,
                     q_if.outStream_TLAST, q_if.outStream_TDATA, q_if.spawnout_queue_en, exp_q[0][64], exp_q[0][63:0]);
          end
        end else begin
          e = exp_q.pop_front();
          if ({q_if.outStream_TLAST, q_if.outStream_TDATA} !== e) begin
            bad++;
            $display("FAIL %s beat%0d got last=%b data=%h want last=%b data=%h", name, beat,
                     q_if.outStream_TLAST, q_if.outStream_TDATA, e[64], e[63:0]);
          end
          beat++;
        end
      end
      if (q_if.spawnout_queue_en && q_if.spawnout_queue_we == 8'hFF && q_if.spawnout_queue_addr == 32'(base * 8)) begin
        done = 1;
        enable = 1'b0;
      end
    end
    q_if.outStream_TREADY = 1'b1;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s timeout got no header clear want header clear", name);
    end
    total++;
    if (cycles != 3 + 4 * (len - 1) + 1 + stall_len) begin
      bad++;
      $display("FAIL %s cycles got %0d want %0d", name, cycles, 3 + 4 * (len - 1) + 1 + stall_len);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s missing_beats got %0d left want 0", name, exp_q.size());
    end
    @(posedge clk);
    #1;
    nerr = 0;
    if (rd_log.size() - rd0 != len) nerr = 1000;
    else for (int k = 0; k < len; k++) if (rd_log[rd0 + k] != ((base + k) % QL) * 8) nerr++;
    total++;
    if (nerr != 0) begin
      bad++;
      $display("FAIL %s read_order got %0d reads (%0d wrong) want %0d", name, rd_log.size() - rd0, nerr % 1000, len);
    end
    nerr = 0;
    if (clr_log.size() - clr0 != len) nerr = 1000;
    else for (int k = 0; k < len; k++) begin
      exp_addr = ((base + ((k < len - 1) ? k + 1 : 0)) % QL) * 8;
      if (clr_log[clr0 + k] != exp_addr) nerr++;
    end
    total++;
    if (nerr != 0) begin
      bad++;
      $display("FAIL %s clear_order got %0d clears (%0d wrong) want %0d header last", name, clr_log.size() - clr0, nerr % 1000, len);
    end
    nerr = 0;
    for (int k = 0; k < len; k++) if (mem[(base + k) % QL] !== 64'h0) nerr++;
    total++;
    if (nerr != 0) begin
      bad++;
      $display("FAIL %s zeroed got %0d nonzero words want 0", name, nerr);
    end
  endtask

  // Starts a poll on an empty header to reveal where rd_ptr points.
  task automatic check_rd_ptr(input string name, input int exp_ptr);
    bit found;
    found = 0;
    @(negedge clk);
    enable = 1'b1;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (q_if.spawnout_queue_en) begin
        found = 1;
        total++;
        if (q_if.spawnout_queue_addr !== 32'(exp_ptr * 8)) begin
          bad++;
          $display("FAIL %s rd_ptr addr got %h want %h", name, q_if.spawnout_queue_addr, exp_ptr * 8);
        end
      end
    end
    enable = 1'b0;
    total++;
    if (!found) begin
      bad++;
      $display("FAIL %s rd_ptr got no read want read at %h", name, exp_ptr * 8);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    enable = 1'b0;
    q_if.outStream_TREADY = 1'b1;
    @(negedge clk);
    total++;
    if ({q_if.spawnout_queue_addr, q_if.spawnout_queue_en, q_if.spawnout_queue_we, q_if.spawnout_queue_din,
         q_if.outStream_TDATA, q_if.outStream_TVALID, q_if.outStream_TLAST} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got addr=%h en=%b we=%h tdata=%h tvalid=%b tlast=%b want all 0",
               q_if.spawnout_queue_addr, q_if.spawnout_queue_en, q_if.spawnout_queue_we,
               q_if.outStream_TDATA, q_if.outStream_TVALID, q_if.outStream_TLAST);
    end
    do_reset();
  endtask

  task automatic test_min_slot();
    do_reset();
    clear_mem();
    set_min_slot();
    load_slot(0, 4);
    drain_slot("min", 0, 4, -1, 0);
    check_rd_ptr("min_ptr", 4);
  endtask

  task automatic test_full_slot();
    do_reset();
    clear_mem();
    slot_w[0] = 64'h8000000001010200;
    for (int k = 1; k < 10; k++) slot_w[k] = 64'hC0DE_0000_0000_0000 | 64'(k * 17);
    load_slot(0, 10);
    drain_slot("full", 0, 10, -1, 0);
    check_rd_ptr("full_ptr", 10);
  endtask

  task automatic test_backpressure();
    do_reset();
    clear_mem();
    set_min_slot();
    load_slot(0, 4);
    drain_slot("backpressure", 0, 4, 1, 5);
  endtask

  task automatic test_wrap();
    do_reset();
    clear_mem();
    slot_w[0] = 64'h8000000000000A00;
    for (int k = 1; k < 14; k++) slot_w[k] = 64'hA000 + 64'(k);
    load_slot(0, 14);
    drain_slot("wrap_pre", 0, 14, -1, 0);
    check_rd_ptr("wrap_pre_ptr", 14);
    set_min_slot();
    load_slot(14, 4);
    drain_slot("wrap", 14, 4, -1, 0);
    check_rd_ptr("wrap_ptr", 2);
  endtask

  task automatic test_empty_poll();
    int last_c, nvalid, npoll, nen;
    do_reset();
    clear_mem();
    last_c = -1; nvalid = 0; npoll = 0; nen = 0;
    @(negedge clk);
    enable = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (q_if.outStream_TVALID) nvalid++;
      if (q_if.spawnout_queue_en && q_if.spawnout_queue_we == 8'h00) begin
        if (last_c >= 0) begin
          total++;
          if (c - last_c != 3 || q_if.spawnout_queue_addr !== 32'h0) begin
            bad++;
            $display("FAIL poll_period got %0d cycles addr=%h want 3 cycles addr=0", c - last_c, q_if.spawnout_queue_addr);
          end
        end
        last_c = c;
        npoll++;
      end
    end
    total++;
    if (nvalid != 0) begin
      bad++;
      $display("FAIL empty_tvalid got %0d valid cycles want 0", nvalid);
    end
    total++;
    if (npoll != 10) begin
      bad++;
      $display("FAIL poll_count got %0d want 10", npoll);
    end
    enable = 1'b0;
    repeat (4) @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (q_if.spawnout_queue_en) nen++;
    end
    total++;
    if (nen != 0) begin
      bad++;
      $display("FAIL disabled_en got %0d en cycles want 0", nen);
    end
  endtask

  task automatic test_reset_mid_slot();
    int beats;
    do_reset();
    clear_mem();
    set_min_slot();
    load_slot(0, 4);
    beats = 0;
    @(negedge clk);
    enable = 1'b1;
    for (int c = 0; c < 60 && beats < 2; c++) begin
      @(negedge clk);
      if (q_if.outStream_TVALID && q_if.outStream_TREADY) beats++;
    end
    total++;
    if (beats != 2) begin
      bad++;
      $display("FAIL midreset_beats got %0d want 2", beats);
    end
    @(posedge clk);
    #1;
    rstn = 1'b0;
    enable = 1'b0;
    #1;
    total++;
    if ({q_if.spawnout_queue_addr, q_if.spawnout_queue_en, q_if.spawnout_queue_we,
         q_if.outStream_TDATA, q_if.outStream_TVALID, q_if.outStream_TLAST} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs got addr=%h en=%b we=%h tdata=%h tvalid=%b tlast=%b want all 0",
               q_if.spawnout_queue_addr, q_if.spawnout_queue_en, q_if.spawnout_queue_we,
               q_if.outStream_TDATA, q_if.outStream_TVALID, q_if.outStream_TLAST);
    end
    repeat (2) @(negedge clk);
    total++;
    if (mem[0] !== slot_w[0] || mem[1] !== slot_w[1] || mem[2] !== slot_w[2] || mem[3] !== slot_w[3]) begin
      bad++;
      $display("FAIL midreset_mem got %h %h %h %h want %h %h %h %h", mem[0], mem[1], mem[2], mem[3],
               slot_w[0], slot_w[1], slot_w[2], slot_w[3]);
    end
    rstn = 1'b1;
    @(negedge clk);
    drain_slot("midreset_restart", 0, 4, -1, 0);
  endtask

  initial begin
    test_reset();
    test_min_slot();
    test_full_slot();
    test_backpressure();
    test_wrap();
    test_empty_poll();
    test_reset_mid_slot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
